maxnet_iter_ctrl: RTL and testbench
===================================

MAXNET_ITER_CTRL -- requirements
Module: maxnet_iter_ctrl

Interface
REQ-001 SHALL provide parameter: MAX_ITER, 64, iteration limit before forced termination (1..255).
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: start  input  1  request new competition; sampled only in IDLE and DONE.
REQ-005 SHALL provide ports: x1..x4  input  32 each  initial IEEE-754 single activations.
REQ-006 SHALL provide ports: r1..r4  input  32 each  registered, ReLU-clamped outputs of the four processing units.
REQ-007 SHALL provide ports: a1..a4  output  32 each  current activations driven to every processing unit.
REQ-008 SHALL provide port: result_ld  output  1  load strobe to the processing units' result registers.
REQ-009 SHALL provide ports: busy  output  1, high in every state except IDLE and DONE; done  output  1, high in DONE.
REQ-010 SHALL provide ports: winner  output  2  surviving index; winner_val  output  32  its value.
REQ-011 SHALL provide ports: no_winner  output  1  all activations zero; timeout  output  1  MAX_ITER reached with more than one survivor.
REQ-012 SHALL provide port: iter_cnt  output  8  completed iterations of the current run.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, COMPUTE, CAPTURE, CHECK, DONE, one cycle each except IDLE and DONE.
REQ-014 IDLE/DONE with start=1 SHALL go to LOAD; start=0 SHALL hold state; start in any other state SHALL be ignored.
REQ-015 LOAD SHALL latch x1..x4 into activation registers, clear iter_cnt, timeout, no_winner, and go to CHECK.
REQ-016 COMPUTE SHALL assert result_ld=1 for exactly one cycle and go to CAPTURE; result_ld SHALL be 0 in all other states.
REQ-017 CAPTURE SHALL latch r1..r4 into activation registers, increment iter_cnt by 1, and go to CHECK.
REQ-018 An activation SHALL count as nonzero iff bits[30:0] != 0 and bit[31] == 0 (negative and -0 treated as zero).
REQ-019 CHECK with nonzero count == 1 SHALL go to DONE with winner = that index, winner_val = its value.
REQ-020 CHECK with nonzero count == 0 SHALL go to DONE with no_winner=1, winner=0, winner_val=0.
REQ-021 CHECK with count >= 2 and iter_cnt == MAX_ITER SHALL go to DONE with timeout=1, winner = lowest-index largest magnitude (bits[30:0] unsigned compare, ties to lower index), winner_val = its value.
REQ-022 CHECK with count >= 2 and iter_cnt < MAX_ITER SHALL go to COMPUTE.
REQ-023 a1..a4 SHALL equal the activation registers at all times.
REQ-024 Latency: done SHALL rise 3 cycles after start is sampled for a 0-iteration run, and 3+3n cycles for an n-iteration run.
REQ-025 winner, winner_val, no_winner, timeout, iter_cnt SHALL hold stable through DONE until the next LOAD.
REQ-026 iter_cnt SHALL never exceed MAX_ITER; no wrap-around.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE and clear all outputs and registers to 0 (a1..a4, winner_val, iter_cnt, winner, flags, busy, done, result_ld), regardless of state, including mid-COMPUTE.
REQ-028 After rst deasserts, the block SHALL remain in IDLE until start=1 is sampled.

Verification
REQ-029 x={0x3F800000,0,0,0}, start -> done after 3 cycles, iter_cnt=0, winner=0, winner_val=0x3F800000, result_ld never asserted.
REQ-030 x all 0x3F000000; bench returns r={0x3F000000,0,0x3E800000,0}, then r={0x3E800000,0,0,0} -> done at cycle 9, iter_cnt=2, winner=0, winner_val=0x3E800000.
REQ-031 MAX_ITER=4; r always {0x3F000000,0x3F400000,0x3E800000,0x3F400000} -> done at cycle 15, timeout=1, iter_cnt=4, winner=1, winner_val=0x3F400000.
REQ-032 x all nonzero; r={0,0x80000000,0,0} -> no_winner=1, winner=0, winner_val=0, iter_cnt=1.
REQ-033 Assert rst=0 during COMPUTE -> same cycle busy=0, result_ld=0, a1..a4=0; start pulses during busy -> no restart and iter_cnt unaffected.

Source files
------------

// File: rtl/maxnet_iter_ctrl.sv
// Iteration controller for a four-unit MAXNET winner-take-all competition.
// Sequences load / compute / capture / check rounds until a single survivor remains.
module maxnet_iter_ctrl #(
  parameter int unsigned MAX_ITER = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [31:0] x3,
  input  logic [31:0] x4,
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic [31:0] r3,
  input  logic [31:0] r4,
  output logic [31:0] a1,
  output logic [31:0] a2,
  output logic [31:0] a3,
  output logic [31:0] a4,
  output logic        result_ld,
  output logic        busy,
  output logic        done,
  output logic [1:0]  winner,
  output logic [31:0] winner_val,
  output logic        no_winner,
  output logic        timeout,
  output logic [7:0]  iter_cnt
);

  localparam logic [7:0] ITER_LIMIT = 8'(MAX_ITER);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, CAPTURE, CHECK, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] act [4];
  logic [3:0]  nz;
  logic [2:0]  nz_cnt;
  logic [1:0]  best_idx;
  logic [30:0] best_mag;

  assign a1 = act[0];
  assign a2 = act[1];
  assign a3 = act[2];
  assign a4 = act[3];

  // Survivors are strictly positive values; among them pick the largest
  // magnitude, strict '>' keeps ties on the lower index.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    nz       = '0;
    nz_cnt   = '0;
    best_idx = '0;
    best_mag = '0;
    for (int i = 0; i < 4; i++) begin
      nz[i]  = ~act[i][31] & (act[i][30:0] != '0);
      nz_cnt = nz_cnt + 3'(nz[i]);
      if (nz[i] && (act[i][30:0] > best_mag)) begin
        best_idx = 2'(i);
        best_mag = act[i][30:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD:       state_nxt = CHECK;
      COMPUTE:    state_nxt = CAPTURE;
      CAPTURE:    state_nxt = CHECK;
      CHECK: begin
        if (nz_cnt <= 3'd1 || iter_cnt >= ITER_LIMIT) state_nxt = DONE;
        else                                          state_nxt = COMPUTE;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE) && (state != DONE);
    done      = (state == DONE);
    result_ld = (state == COMPUTE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the four activation words are plain registers, so clearing them on reset is cheap and keeps a1..a4 defined.
      act        <= '{default: '0};
      iter_cnt   <= '0;
      winner     <= '0;
      winner_val <= '0;
      no_winner  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        LOAD: begin
          act       <= '{x1, x2, x3, x4};
          iter_cnt  <= '0;
          timeout   <= 1'b0;
          no_winner <= 1'b0;
        end
        CAPTURE: begin
          act <= '{r1, r2, r3, r4};
          if (iter_cnt < ITER_LIMIT) iter_cnt <= iter_cnt + 8'd1;
        end
        CHECK: begin
          if (nz_cnt == 3'd0) begin
            no_winner  <= 1'b1;
            winner     <= '0;
            winner_val <= '0;
          end else if (nz_cnt == 3'd1 || iter_cnt >= ITER_LIMIT) begin
            winner     <= best_idx;
            winner_val <= act[best_idx];
            timeout    <= (nz_cnt != 3'd1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_iter_ctrl.sv
// Scenario bench for maxnet_iter_ctrl: the bench plays the four processing units
// and scores each run's result against expectations queued at start time.
module tb_maxnet_iter_ctrl;

  localparam int unsigned MAX_ITER = 4;

  typedef logic [3:0][31:0] vec_t;
  typedef struct packed {
    logic [1:0]  winner;
    logic [31:0] wval;
    logic        nw;
    logic        to;
    logic [7:0]  iter;
    logic [15:0] lat;
    logic [7:0]  lds;
    vec_t        act;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] x1, x2, x3, x4, r1, r2, r3, r4;
  logic [31:0] a1, a2, a3, a4, winner_val;
  logic        result_ld, busy, done, no_winner, timeout;
  logic [1:0]  winner;
  logic [7:0]  iter_cnt;

  exp_t exp_q[$];
  vec_t r_q[$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  maxnet_iter_ctrl #(.MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .result_ld(result_ld), .busy(busy), .done(done),
    .winner(winner), .winner_val(winner_val),
    .no_winner(no_winner), .timeout(timeout), .iter_cnt(iter_cnt)
  );

  function automatic vec_t vec(input logic [31:0] v0, v1, v2, v3);
    return {v3, v2, v1, v0};
  endfunction

  function automatic exp_t mk_exp(input logic [1:0] w, input logic [31:0] wv, input logic nw, to,
                                  input logic [7:0] it, input logic [15:0] lat, input logic [7:0] lds,
                                  input vec_t act);
    exp_t e;
    e.winner = w; e.wval = wv; e.nw = nw; e.to = to;
    e.iter = it; e.lat = lat; e.lds = lds; e.act = act;
    return e;
  endfunction

  // Starts one run, answers each result_ld with the next queued PU result,
  // then pops the expected record and scores the finished run.
  task automatic run_case(input string name, input vec_t x, input exp_t e, input bit poke);
    int   cycles = 0;
    int   lds = 0;
    bit   seen = 0;
    exp_t ex;
    exp_q.push_back(e);
    @(negedge clk);
    {x4, x3, x2, x1} = x;
    start = 1'b1;
    while (cycles < 60) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (result_ld) begin
        lds++;
        if (r_q.size() > 0) {r4, r3, r2, r1} = r_q.pop_front();
      end
      if (done) begin
        start = 1'b0;
        seen  = 1;
        break;
      end
      start = poke;
    end
    start = 1'b0;
    ex = exp_q.pop_front();
    total++;
    if (!seen) begin
      $display("FAIL %s no done within %0d cycles", name, cycles);
      return;
    end
    passed++;
    total++; if (cycles !== int'(ex.lat)) $display("FAIL %s latency got %0d exp %0d", name, cycles, ex.lat); else passed++;
    total++; if (lds !== int'(ex.lds)) $display("FAIL %s result_ld pulses got %0d exp %0d", name, lds, ex.lds); else passed++;
    total++; if (winner !== ex.winner) $display("FAIL %s winner got %0d exp %0d", name, winner, ex.winner); else passed++;
    total++; if (winner_val !== ex.wval) $display("FAIL %s winner_val got %h exp %h", name, winner_val, ex.wval); else passed++;
    total++; if (no_winner !== ex.nw) $display("FAIL %s no_winner got %b exp %b", name, no_winner, ex.nw); else passed++;
    total++; if (timeout !== ex.to) $display("FAIL %s timeout got %b exp %b", name, timeout, ex.to); else passed++;
    total++; if (iter_cnt !== ex.iter) $display("FAIL %s iter_cnt got %0d exp %0d", name, iter_cnt, ex.iter); else passed++;
    total++; if ({a4, a3, a2, a1} !== ex.act) $display("FAIL %s activations got %h exp %h", name, {a4, a3, a2, a1}, ex.act); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL %s busy in done got %b exp 0", name, busy); else passed++;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({done, winner, winner_val, iter_cnt} !== {1'b1, ex.winner, ex.wval, ex.iter})
      $display("FAIL %s done hold got %b/%0d/%h/%0d exp 1/%0d/%h/%0d", name, done, winner, winner_val,
               iter_cnt, ex.winner, ex.wval, ex.iter);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0;
    {x1, x2, x3, x4, r1, r2, r3, r4} = '0;
    repeat (3) @(negedge clk);
    total++; if ({busy, done, result_ld} !== 3'b000) $display("FAIL reset ctrl got %b exp 000", {busy, done, result_ld}); else passed++;
    total++; if ({a4, a3, a2, a1} !== '0) $display("FAIL reset act got %h exp 0", {a4, a3, a2, a1}); else passed++;
    total++; if ({winner, winner_val, no_winner, timeout, iter_cnt} !== '0)
      $display("FAIL reset results got %h exp 0", {winner, winner_val, no_winner, timeout, iter_cnt}); else passed++;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++; if ({busy, done} !== 2'b00) $display("FAIL idle hold got %b exp 00", {busy, done}); else passed++;
    end
  endtask

  task automatic test_single_survivor();
    run_case("single", vec(32'h3F80_0000, 0, 0, 0),
             mk_exp(2'd0, 32'h3F80_0000, 0, 0, 8'd0, 16'd3, 8'd0, vec(32'h3F80_0000, 0, 0, 0)), 0);
  endtask

  task automatic test_negative_zero();
    vec_t x = vec(32'h8000_0000, 32'hBF80_0000, 0, 32'h4000_0000);
    run_case("neg_zero", x, mk_exp(2'd3, 32'h4000_0000, 0, 0, 8'd0, 16'd3, 8'd0, x), 0);
  endtask

  task automatic test_two_iter(input bit poke);
    vec_t x = vec(32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000);
    r_q.push_back(vec(32'h3F00_0000, 0, 32'h3E80_0000, 0));
    r_q.push_back(vec(32'h3E80_0000, 0, 0, 0));
    run_case(poke ? "start_ignored" : "two_iter", x,
             mk_exp(2'd0, 32'h3E80_0000, 0, 0, 8'd2, 16'd9, 8'd2, vec(32'h3E80_0000, 0, 0, 0)), poke);
  endtask

  task automatic test_no_winner();
    vec_t x = vec(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    r_q.push_back(vec(0, 32'h8000_0000, 0, 0));
    run_case("no_winner", x, mk_exp(2'd0, 32'h0, 1, 0, 8'd1, 16'd6, 8'd1, vec(0, 32'h8000_0000, 0, 0)), 0);
  endtask

  task automatic test_timeout();
    vec_t x = vec(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    vec_t r = vec(32'h3F00_0000, 32'h3F40_0000, 32'h3E80_0000, 32'h3F40_0000);
    repeat (MAX_ITER) r_q.push_back(r);
    run_case("timeout", x, mk_exp(2'd1, 32'h3F40_0000, 0, 1, 8'(MAX_ITER), 16'(3 + 3 * MAX_ITER), 8'(MAX_ITER), r), 0);
  endtask

  task automatic test_abort();
    bit hit = 0;
    @(negedge clk);
    {x4, x3, x2, x1} = vec(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (result_ld) begin
        hit = 1;
        break;
      end
    end
    total++; if (!hit) $display("FAIL abort compute not reached got 0 exp 1"); else passed++;
    #1 rst = 1'b0;
    #1;
    total++; if ({busy, done, result_ld} !== 3'b000) $display("FAIL abort ctrl got %b exp 000", {busy, done, result_ld}); else passed++;
    total++; if ({a4, a3, a2, a1} !== '0) $display("FAIL abort act got %h exp 0", {a4, a3, a2, a1}); else passed++;
    total++; if (iter_cnt !== 8'd0) $display("FAIL abort iter_cnt got %0d exp 0", iter_cnt); else passed++;
    r_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++; if ({busy, done} !== 2'b00) $display("FAIL post abort idle got %b exp 00", {busy, done}); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    test_single_survivor();
    test_no_winner();
  endtask

  initial begin
    test_reset();
    test_single_survivor();
    test_negative_zero();
    test_two_iter(0);
    test_no_winner();
    test_timeout();
    test_two_iter(1);
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
